// File: rtl/core_seq_ctrl.sv
// Sequencer for the systolic-array core: per iteration it streams weights, loads the kernel,
// streams activations, executes and drains, then repeats for the programmed iteration count.
module core_seq_ctrl #(
    parameter int w_cycles     = 4,
    parameter int a_cycles     = 8,
    parameter int drain_cycles = 16,
    parameter int iter_bw      = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [iter_bw-1:0] num_iter,
    output logic               data_req,
    output logic               data_sel,
    input  logic               data_valid,
    input  logic               full_l0,
    input  logic               ready_l0,
    output logic               wr_l0,
    output logic               rd_l0,
    output logic [1:0]         inst_w,
    output logic               mode,
    output logic               cen,
    output logic               acc,
    output logic               busy,
    output logic               done
);
    // state  | meaning
    // IDLE   | waiting for start
    // W_WR   | writing weight vectors into L0
    // W_LOAD | reading weights out of L0 as kernel-load instructions
    // A_WR   | writing activation vectors into L0
    // GAP    | single quiet cycle before execute
    // EXEC   | reading activations out of L0 as execute instructions
    // DRAIN  | idle while partial sums flush
    // FIN    | one-cycle done pulse
    typedef enum logic [2:0] {IDLE, W_WR, W_LOAD, A_WR, GAP, EXEC, DRAIN, FIN} state_t;

    localparam int max_wa = (w_cycles > a_cycles) ? w_cycles : a_cycles;
    localparam int max_c  = (max_wa > drain_cycles) ? max_wa : drain_cycles;
    localparam int cnt_bw = $clog2(max_c + 1);

    localparam logic [cnt_bw-1:0] w_last = cnt_bw'(w_cycles - 1);
    localparam logic [cnt_bw-1:0] a_last = cnt_bw'(a_cycles - 1);
    localparam logic [cnt_bw-1:0] d_last = cnt_bw'(drain_cycles - 1);

    state_t             state;
    logic [cnt_bw-1:0]  cnt;
    logic [iter_bw-1:0] it;
    logic [iter_bw-1:0] num_iter_q;
    logic [iter_bw-1:0] it_next;
    logic               mode_r;
    logic               wr_phase;
    logic               rd_phase;

    assign it_next  = it + iter_bw'(1);
    assign wr_phase = (state == W_WR) || (state == A_WR);
    assign rd_phase = (state == W_LOAD) || (state == EXEC);

    always_comb begin
        data_req = wr_phase && !full_l0;
        wr_l0    = data_req && data_valid;
        rd_l0    = rd_phase && ready_l0;
        inst_w   = 2'b00;
        if (rd_l0)
            inst_w = (state == W_LOAD) ? 2'b01 : 2'b10;
    end

    assign data_sel = (state == A_WR);
    assign mode     = mode_r;
    assign busy     = (state != IDLE);
    assign cen      = !busy;
    assign done     = (state == FIN);
    assign acc      = ((state == EXEC) || (state == DRAIN)) && (it != '0);

    // mode is registered so it holds its last value while IDLE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            it         <= '0;
            num_iter_q <= '0;
            mode_r     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        num_iter_q <= num_iter;
                        it         <= '0;
                        cnt        <= '0;
                        if (num_iter == '0) begin
                            state <= FIN;
                        end else begin
                            state  <= W_WR;
                            mode_r <= 1'b0;
                        end
                    end
                end
                W_WR: begin
                    if (wr_l0) begin
                        if (cnt == w_last) begin
                            cnt   <= '0;
                            state <= W_LOAD;
                        end else begin
                            cnt <= cnt + cnt_bw'(1);
                        end
                    end
                end
                W_LOAD: begin
                    if (rd_l0) begin
                        if (cnt == w_last) begin
                            cnt   <= '0;
                            state <= A_WR;
                        end else begin
                            cnt <= cnt + cnt_bw'(1);
                        end
                    end
                end
                A_WR: begin
                    if (wr_l0) begin
                        if (cnt == a_last) begin
                            cnt   <= '0;
                            state <= GAP;
                        end else begin
                            cnt <= cnt + cnt_bw'(1);
                        end
                    end
                end
                GAP: begin
                    cnt    <= '0;
                    state  <= EXEC;
                    mode_r <= 1'b1;
                end
                EXEC: begin
                    if (rd_l0) begin
                        if (cnt == a_last) begin
                            cnt   <= '0;
                            state <= DRAIN;
                        end else begin
                            cnt <= cnt + cnt_bw'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (cnt == d_last) begin
                        cnt <= '0;
                        it  <= it_next;
                        if (it_next < num_iter_q) begin
                            state  <= W_WR;
                            mode_r <= 1'b0;
                        end else begin
                            state <= FIN;
                        end
                    end else begin
                        cnt <= cnt + cnt_bw'(1);
                    end
                end
                FIN: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed bench for core_seq_ctrl: runs jobs with scripted stalls and checks strobe counts,
// flags and done timing against hand-computed cycle numbers.
module tb_core_seq_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] num_iter;
    logic       data_req;
    logic       data_sel;
    logic       data_valid;
    logic       full_l0;
    logic       ready_l0;
    logic       wr_l0;
    logic       rd_l0;
    logic [1:0] inst_w;
    logic       mode;
    logic       cen;
    logic       acc;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    int n_w0, n_w1, n_r1, n_r2, n_acc, n_mode, n_wfull, n_rstall, n_bad, done_cyc;

    core_seq_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_iter   (num_iter),
        .data_req   (data_req),
        .data_sel   (data_sel),
        .data_valid (data_valid),
        .full_l0    (full_l0),
        .ready_l0   (ready_l0),
        .wr_l0      (wr_l0),
        .rd_l0      (rd_l0),
        .inst_w     (inst_w),
        .mode       (mode),
        .cen        (cen),
        .acc        (acc),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr"},   int'(wr_l0),    0);
        check({tag, "_rd"},   int'(rd_l0),    0);
        check({tag, "_inst"}, int'(inst_w),   0);
        check({tag, "_mode"}, int'(mode),     0);
        check({tag, "_cen"},  int'(cen),      1);
        check({tag, "_acc"},  int'(acc),      0);
        check({tag, "_busy"}, int'(busy),     0);
        check({tag, "_done"}, int'(done),     0);
        check({tag, "_req"},  int'(data_req), 0);
    endtask

    // Cycle k is the clock period after edge k-1, where edge 0 samples start.
    task automatic run_job(input int n, input bit hold_start, input int full_from, input int full_len,
                           input bit dv_alt, input int rdy_from, input int rdy_len, input int spulse);
        n_w0 = 0; n_w1 = 0; n_r1 = 0; n_r2 = 0; n_acc = 0; n_mode = 0;
        n_wfull = 0; n_rstall = 0; n_bad = 0; done_cyc = -1;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b1;
        num_iter = 8'(n);
        @(posedge clk);
        #1;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            start      = hold_start || (cyc == spulse);
            if (cyc == spulse) num_iter = 8'd0;
            full_l0    = (cyc >= full_from) && (cyc < full_from + full_len);
            ready_l0   = !((cyc >= rdy_from) && (cyc < rdy_from + rdy_len));
            data_valid = !(dv_alt && cyc >= 13 && cyc <= 19 && (cyc % 2 == 1));
            #2;
            if (wr_l0 && !data_sel) n_w0++;
            if (wr_l0 && data_sel) n_w1++;
            if (rd_l0 && inst_w == 2'b01) n_r1++;
            if (rd_l0 && inst_w == 2'b10) n_r2++;
            if (wr_l0 && full_l0) n_wfull++;
            if (!ready_l0 && (rd_l0 || inst_w != 2'b00)) n_rstall++;
            if ((wr_l0 && rd_l0) || (rd_l0 == (inst_w == 2'b00)) || (cen != !busy) || (acc && !mode))
                n_bad++;
            if (acc) n_acc++;
            if (mode && busy && !done) n_mode++;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            @(posedge clk);
            #1;
        end
        full_l0    = 1'b0;
        ready_l0   = 1'b1;
        data_valid = 1'b1;
        if (!hold_start) start = 1'b0;
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        num_iter   = 8'd0;
        data_valid = 1'b1;
        full_l0    = 1'b0;
        ready_l0   = 1'b1;
        #12;
        check_reset_outputs("por");
        @(negedge clk);
        reset = 1'b1;

        // single iteration, no stalls
        run_job(1, 1'b0, 0, 0, 1'b0, 0, 0, 0);
        check("single_done_cyc", done_cyc, 42);
        check("single_w0", n_w0, 4);
        check("single_r1", n_r1, 4);
        check("single_w1", n_w1, 8);
        check("single_r2", n_r2, 8);
        check("single_mode", n_mode, 24);
        check("single_acc", n_acc, 0);
        check("single_bad", n_bad, 0);
        @(posedge clk);
        #3;
        check("idle_busy", int'(busy), 0);
        check("idle_cen", int'(cen), 1);
        check("idle_mode_hold", int'(mode), 1);

        // three iterations
        run_job(3, 1'b0, 0, 0, 1'b0, 0, 0, 0);
        check("three_done_cyc", done_cyc, 124);
        check("three_acc", n_acc, 48);
        check("three_w0", n_w0, 12);
        check("three_r2", n_r2, 24);
        check("three_mode", n_mode, 72);
        check("three_bad", n_bad, 0);

        // write stalls: full for cycles 2-4, data_valid low on cycles 13,15,17,19
        run_job(1, 1'b0, 2, 3, 1'b1, 0, 0, 0);
        check("wstall_done_cyc", done_cyc, 49);
        check("wstall_w0", n_w0, 4);
        check("wstall_w1", n_w1, 8);
        check("wstall_wfull", n_wfull, 0);
        check("wstall_bad", n_bad, 0);

        // read stall: ready low for cycles 20-21 inside EXEC
        run_job(1, 1'b0, 0, 0, 1'b0, 20, 2, 0);
        check("rstall_done_cyc", done_cyc, 44);
        check("rstall_r2", n_r2, 8);
        check("rstall_quiet", n_rstall, 0);
        check("rstall_bad", n_bad, 0);

        // zero count
        run_job(0, 1'b0, 0, 0, 1'b0, 0, 0, 0);
        check("zero_done_cyc", done_cyc, 1);
        check("zero_wr", n_w0 + n_w1, 0);
        check("zero_rd", n_r1 + n_r2, 0);

        // start pulse during EXEC is ignored
        run_job(1, 1'b0, 0, 0, 1'b0, 0, 0, 20);
        check("ign_done_cyc", done_cyc, 42);
        check("ign_r2", n_r2, 8);
        check("ign_w1", n_w1, 8);

        // reset in the middle of EXEC
        @(posedge clk);
        @(negedge clk);
        start    = 1'b1;
        num_iter = 8'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        check("mid_exec_mode", int'(mode), 1);
        check("mid_exec_inst", int'(inst_w), 2);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        reset = 1'b1;
        run_job(1, 1'b0, 0, 0, 1'b0, 0, 0, 0);
        check("after_rst_done_cyc", done_cyc, 42);
        check("after_rst_w0", n_w0, 4);
        check("after_rst_r2", n_r2, 8);
        check("after_rst_acc", n_acc, 0);

        // back-to-back: start held high restarts in the first IDLE cycle after FIN
        run_job(1, 1'b1, 0, 0, 1'b0, 0, 0, 0);
        check("b2b_done_cyc", done_cyc, 42);
        @(posedge clk);
        #3;
        check("b2b_idle_busy", int'(busy), 0);
        @(posedge clk);
        #3;
        check("b2b_restart_busy", int'(busy), 1);
        check("b2b_restart_req", int'(data_req), 1);
        check("b2b_restart_sel", int'(data_sel), 0);
        start = 1'b0;
        #1;
        reset = 1'b0;
        #2;
        reset = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/core_seq_ctrl.md
# core_seq_ctrl

Sequencer for the systolic-array `core`. Per iteration it:
- streams weight vectors into the L0 FIFO and issues the kernel-load instruction;
- streams activation vectors into L0 and issues the execute instruction;
- idles the core for a drain window while partial sums flush.

It repeats for a programmed number of iterations and accumulates into psum memory after the first. It replaces hand-written stimulus sequencing: the data source only answers requests, and this block owns every `core` control pin.

## Interface
Parameters:
- `w_cycles`, 4: weight vectors written and read per iteration.
- `a_cycles`, 8: activation vectors written and executed per iteration.
- `drain_cycles`, 16: idle cycles after execute.
- `iter_bw`, 8: width of the iteration count.

Ports:
- `clk`  in  1: the single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `start`  in  1: begin a job; sampled only in IDLE.
- `num_iter`  in  iter_bw: iteration count, latched on accepted `start`.
- `data_req`  out  1: source must drive the next vector onto `in_l0` this cycle.
- `data_sel`  out  1: 0 = weight stream, 1 = activation stream.
- `data_valid`  in  1: source has a vector on `in_l0` this cycle.
- `full_l0`  in  1: L0 FIFO full.
- `ready_l0`  in  1: L0 FIFO holds at least one vector.
- `wr_l0`  out  1: L0 write strobe.
- `rd_l0`  out  1: L0 read strobe.
- `inst_w`  out  2: 00 idle, 01 kernel load, 10 execute.
- `mode`  out  1: 0 in load phases, 1 in EXEC and DRAIN.
- `cen`  out  1: psum memory enable, active-low.
- `acc`  out  1: accumulate into psum memory.
- `busy`  out  1: job in progress.
- `done`  out  1: one-cycle pulse at job end.

## Operation
States are IDLE, W_WR, W_LOAD, A_WR, GAP, EXEC, DRAIN and FIN. A phase counter clears on every state entry; an iteration counter `it` clears on `start`.

- **IDLE:** on `start`, latch `num_iter` and clear `it`.
  - If `num_iter` == 0, go to FIN.
  - Otherwise go to W_WR.
  - `start` outside IDLE is ignored.
- **W_WR:** `data_sel`=0 and `data_req` = !`full_l0`. `wr_l0` = `data_req` & `data_valid`. Each `wr_l0` increments the counter. After the `w_cycles`-th write, go to W_LOAD.
- **W_LOAD:** `rd_l0` = `ready_l0`. `inst_w` = 01 when `rd_l0`, else 00. Each read increments the counter. After `w_cycles` reads, go to A_WR.
- **A_WR:** same as W_WR with `data_sel`=1 and `a_cycles` writes, then go to GAP.
- **GAP:** exactly one cycle with no strobes, then go to EXEC.
- **EXEC:** `mode`=1 and `rd_l0` = `ready_l0`. `inst_w` = 10 when `rd_l0`, else 00. After `a_cycles` reads, go to DRAIN.
- **DRAIN:** `mode`=1 and `inst_w`=00 for `drain_cycles` cycles, then `it` increments.
  - If `it` < `num_iter`, go to W_WR.
  - Otherwise go to FIN.
- **FIN:** `done`=1 for one cycle, then go to IDLE.

Output derivation:
- `data_req`, `wr_l0`, `rd_l0` and `inst_w` are combinational from state, counters and inputs.
- `wr_l0` and `rd_l0` are never high in the same cycle.
- `busy` = state != IDLE.
- `cen` = 0 whenever `busy`, otherwise 1.
- `acc` = 1 in EXEC and DRAIN when `it` > 0, otherwise 0.
- `mode` holds its last value in IDLE.

Stalls:
- `full_l0` or a low `data_valid` stalls the write phases.
- A low `ready_l0` stalls the read phases.
- Counters never advance on a stalled cycle, and `inst_w` returns to 00 while stalled.

Counter widths: the phase counter is wide enough for max(`w_cycles`, `a_cycles`, `drain_cycles`), and `it` is `iter_bw` bits. `num_iter` of 255 must complete with no wrap.

## Timing
- **Reset values:** state IDLE, all counters 0. Outputs: `wr_l0`=0, `rd_l0`=0, `inst_w`=00, `mode`=0, `cen`=1, `acc`=0, `busy`=0, `done`=0, `data_req`=0.
- **Reset mid-job:** returns to IDLE immediately, asynchronously, with the values above. No `done` pulse is produced.
- **Start latency:** with `start` sampled at edge 0, W_WR is active in the cycle after edge 0.
- **Unstalled iteration length:** `w_cycles` + `w_cycles` + `a_cycles` + 1 + `a_cycles` + `drain_cycles` cycles. With default parameters this is 41 cycles.
- **Done timing:** `done` is high in cycle 41·N + 1 after the `start` edge, and `busy` falls in the following cycle.
- **Back-to-back jobs:** `start` held high throughout is accepted again in the first IDLE cycle after FIN.

## Test plan
- **Single iteration, no stalls:** `num_iter`=1, `data_valid`=1, `full_l0`=0, `ready_l0`=1, defaults.
  - Exactly 4 `wr_l0` with `data_sel`=0, then 4 `rd_l0` with `inst_w`=01.
  - Then 8 writes with `data_sel`=1, 1 idle cycle, and 8 reads with `inst_w`=10 and `mode`=1.
  - Then 16 drain cycles, and `done` at cycle 42; `acc`=0 throughout.
- **Three iterations:** `num_iter`=3.
  - `done` at cycle 124.
  - `acc`=0 in iteration 0 and 1 in EXEC/DRAIN of iterations 1 and 2.
  - `cen`=0 for the whole job.
- **Stalls:** `data_valid` low on alternate cycles in A_WR, and `full_l0` high for 3 cycles in W_WR.
  - Write counts remain 4 and 8, and `wr_l0` is never high while `full_l0` is high.
  - Completion is delayed by exactly the stalled cycles.
- **Read stall:** `ready_l0` low for 2 cycles in EXEC.
  - `rd_l0`=0 and `inst_w`=00 during those cycles.
  - 8 execute reads total; `done` is delayed 2 cycles.
- **Zero count and ignored start:** `num_iter`=0.
  - `done` in the cycle after `start`, with no `wr_l0` or `rd_l0`.
  - A `start` pulse during EXEC has no effect.
- **Reset mid-job:** `reset` low in the middle of EXEC.
  - All outputs immediately take their reset values.
  - A new `start` runs a clean 41-cycle iteration.
